// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage with IDLE / RUN / HALT control. In RUN it reads the
// word at pc from a combinational instruction memory and registers it toward
// decode, unless a taken branch redirects pc, a halt request stops fetching,
// or decode stalls.
//
// Ports
//   clk          sole clock, all state updates on its rising edge
//   reset        asynchronous active-high reset
//   start        IDLE/HALT -> RUN
//   halt_req     stop fetching, enter HALT
//   stall        decode not ready, hold everything
//   br_valid     branch resolution present (honoured only in RUN)
//   br_taken     resolved branch is taken
//   br_uncond    unconditional branch (imm26) vs conditional (imm19)
//   br_pc        PC of the resolving branch
//   br_instr     instruction word of the resolving branch
//   imem_addr    instruction memory address (= pc)
//   imem_rdata   combinational read data for imem_addr
//   if_instr     registered instruction to decode
//   if_pc        PC of if_instr
//   if_valid     if_instr/if_pc hold a live instruction
//   running      high only in RUN
//   fetch_count  saturating count of delivered instructions
// -----------------------------------------------------------------------------
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic        br_uncond,
   input  logic [63:0] br_pc,
   input  logic [31:0] br_instr,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc,
   output logic        if_valid,
   output logic        running,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [63:0] r_pc;
   logic [31:0] r_if_instr;
   logic [63:0] r_if_pc;
   logic        r_if_valid;
   logic [31:0] r_fetch_count;

   logic        w_in_run;
   logic        w_redirect;
   logic        w_halt_only;
   logic        w_advance;
   logic [63:0] w_off_uncond;
   logic [63:0] w_off_cond;
   logic [63:0] w_target;
   logic        w_unused_bits;

   // Upper opcode bits of the branch word carry no offset information.
   assign w_unused_bits = ^br_instr[31:26];

   assign w_in_run    = (r_state == S_RUN);
   assign w_redirect  = w_in_run & br_valid & br_taken;
   assign w_halt_only = w_in_run & ~w_redirect & halt_req;
   assign w_advance   = w_in_run & ~w_redirect & ~halt_req & ~stall;

   // Word offsets, sign-extended and scaled to bytes; the add wraps mod 2^64.
   assign w_off_uncond = {{36{br_instr[25]}}, br_instr[25:0], 2'b00};
   assign w_off_cond   = {{43{br_instr[23]}}, br_instr[23:5], 2'b00};
   assign w_target     = br_pc + (br_uncond ? w_off_uncond : w_off_cond);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a redirect with halt_req still lands in HALT
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (halt_req) w_state_next = S_HALT;
         S_HALT:  if (start) w_state_next = S_RUN;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      running = w_in_run;
   end

   // Fetch datapath: redirect > halt_req > stall > advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= 64'd0;
         r_if_instr    <= 32'd0;
         r_if_pc       <= 64'd0;
         r_if_valid    <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         if (w_redirect) begin
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
         end else if (w_halt_only) begin
            r_if_valid <= 1'b0;
         end else if (w_advance) begin
            r_if_instr <= imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 64'd4;
            if (r_fetch_count != 32'hFFFF_FFFF) begin
               r_fetch_count <= r_fetch_count + 32'd1;
            end
         end
      end
   end

   assign imem_addr   = r_pc;
   assign if_instr    = r_if_instr;
   assign if_pc       = r_if_pc;
   assign if_valid    = r_if_valid;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        stall = 1'b0;
   logic        br_valid = 1'b0;
   logic        br_taken = 1'b0;
   logic        br_uncond = 1'b0;
   logic [63:0] br_pc = 64'd0;
   logic [31:0] br_instr = 32'd0;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        if_valid;
   logic        running;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt_req    (halt_req),
      .stall       (stall),
      .br_valid    (br_valid),
      .br_taken    (br_taken),
      .br_uncond   (br_uncond),
      .br_pc       (br_pc),
      .br_instr    (br_instr),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_valid    (if_valid),
      .running     (running),
      .fetch_count (fetch_count)
   );

   // Instruction memory: two fixed words, a hash everywhere else
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'd0) return 32'h9100_0421;
      if (a == 64'd4) return 32'h8B02_0020;
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Reference model
   typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
   mstate_t     m_state = M_IDLE;
   logic [63:0] m_pc = 64'd0;
   logic [31:0] m_instr = 32'd0;
   logic [63:0] m_ifpc = 64'd0;
   logic        m_valid = 1'b0;
   logic [31:0] m_cnt = 32'd0;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic [31:0] ins,
                                                 input logic unc);
      longint off;
      if (unc) off = longint'($signed(ins[25:0]));
      else     off = longint'($signed(ins[23:5]));
      return pc + 64'(off * 4);
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_pc = 64'd0; m_instr = 32'd0;
      m_ifpc = 64'd0; m_valid = 1'b0; m_cnt = 32'd0;
   endtask

   task automatic model_step();
      if (reset) begin
         model_reset();
      end else if (m_state != M_RUN) begin
         if (start) m_state = M_RUN;
      end else if (br_valid && br_taken) begin
         m_pc = branch_target(br_pc, br_instr, br_uncond);
         m_valid = 1'b0;
         if (halt_req) m_state = M_HALT;
      end else if (halt_req) begin
         m_state = M_HALT;
         m_valid = 1'b0;
      end else if (!stall) begin
         m_instr = mem_word(m_pc);
         m_ifpc  = m_pc;
         m_valid = 1'b1;
         m_pc    = m_pc + 64'd4;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"},    imem_addr, m_pc);
      chk({tag, ".instr"}, {32'd0, if_instr}, {32'd0, m_instr});
      chk({tag, ".ifpc"},  if_pc, m_ifpc);
      chk({tag, ".valid"}, {63'd0, if_valid}, {63'd0, m_valid});
      chk({tag, ".run"},   {63'd0, running}, {63'd0, (m_state == M_RUN)});
      chk({tag, ".cnt"},   {32'd0, fetch_count}, {32'd0, m_cnt});
      $display("txn %-12s st=%0d pc=%h if_instr=%h if_pc=%h v=%b cnt=%0d",
               tag, m_state, imem_addr, if_instr, if_pc, if_valid, fetch_count);
   endtask

   task automatic clr_in();
      start = 0; halt_req = 0; stall = 0; br_valid = 0;
      br_taken = 0; br_uncond = 0; br_pc = 64'd0; br_instr = 32'd0;
   endtask

   // One clock: model advances on the inputs now applied, DUT sampled #1 later
   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   initial begin
      // Reset
      #1 reset = 1'b1;
      model_reset();
      #1;
      chk_all("reset_async");
      tick("reset_hold");
      tick("reset_hold");
      // start/halt/branch are ignored while reset is high
      start = 1; halt_req = 1; br_valid = 1; br_taken = 1; br_uncond = 1;
      br_pc = 64'h1000; br_instr = 32'h0000_0010;
      tick("reset_ign");
      clr_in();
      reset = 1'b0;
      tick("idle");

      // Start: no fetch in the start cycle, then two words
      start = 1;
      tick("start");
      chk("start.running", {63'd0, running}, 64'd1);
      chk("start.valid", {63'd0, if_valid}, 64'd0);
      start = 0;
      tick("adv1");
      chk("adv1.instr", {32'd0, if_instr}, 64'h9100_0421);
      chk("adv1.ifpc", if_pc, 64'd0);
      tick("adv2");
      chk("adv2.instr", {32'd0, if_instr}, 64'h8B02_0020);
      chk("adv2.ifpc", if_pc, 64'd4);
      chk("adv2.cnt", {32'd0, fetch_count}, 64'd2);

      // Stall three cycles then resume
      stall = 1;
      for (int i = 0; i < 3; i++) tick("stall");
      chk("stall.pc", imem_addr, 64'd8);
      chk("stall.cnt", {32'd0, fetch_count}, 64'd2);
      stall = 0;
      tick("resume");
      chk("resume.ifpc", if_pc, 64'd8);

      // Unconditional redirect backwards
      br_valid = 1; br_taken = 1; br_uncond = 1;
      br_pc = 64'h40; br_instr = 32'h17FF_FFFE;
      tick("br_uncond");
      chk("br_uncond.pc", imem_addr, 64'h38);
      chk("br_uncond.valid", {63'd0, if_valid}, 64'd0);
      clr_in();
      tick("after_br");
      chk("after_br.ifpc", if_pc, 64'h38);

      // Conditional redirect wins over stall
      br_valid = 1; br_taken = 1; br_uncond = 0; stall = 1;
      br_pc = 64'h100; br_instr = 32'hB400_0081;
      tick("br_cond");
      chk("br_cond.pc", imem_addr, 64'h110);
      // Not taken: plain advance
      br_taken = 0; stall = 0;
      tick("br_nt");
      chk("br_nt.pc", imem_addr, 64'h114);
      clr_in();

      // Redirect with halt_req: HALT at target, start resumes there
      br_valid = 1; br_taken = 1; br_uncond = 1; halt_req = 1;
      br_pc = 64'h200; br_instr = 32'h1400_0010;
      tick("br_halt");
      chk("br_halt.pc", imem_addr, 64'h240);
      chk("br_halt.run", {63'd0, running}, 64'd0);
      clr_in();
      br_valid = 1; br_taken = 1; br_pc = 64'h9000;   // ignored in HALT
      tick("halted");
      clr_in();
      start = 1;
      tick("restart");
      start = 0;
      tick("restart_adv");
      chk("restart.ifpc", if_pc, 64'h240);

      // Plain halt holds pc
      halt_req = 1;
      tick("halt");
      clr_in();
      start = 1;
      tick("restart2");
      clr_in();

      // Wrap: redirect to 2^64-4 then advance to 0
      br_valid = 1; br_taken = 1; br_uncond = 1;
      br_pc = 64'd0; br_instr = 32'h17FF_FFFF;
      tick("br_top");
      chk("br_top.pc", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      clr_in();
      tick("wrap");
      chk("wrap.pc", imem_addr, 64'd0);
      chk("wrap.ifpc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         start     = ($urandom_range(0, 9) == 0);
         halt_req  = ($urandom_range(0, 19) == 0);
         stall     = ($urandom_range(0, 4) == 0);
         br_valid  = ($urandom_range(0, 6) == 0);
         br_taken  = $urandom_range(0, 1) == 1;
         br_uncond = $urandom_range(0, 1) == 1;
         br_pc     = {$urandom(), $urandom()};
         br_instr  = $urandom();
         tick("rand");
      end
      clr_in();
      start = 1;
      tick("pre_rst");
      clr_in();
      tick("pre_rst_adv");

      // Asynchronous reset between clock edges
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk_all("rst_mid");
      chk("rst_mid.valid", {63'd0, if_valid}, 64'd0);
      tick("rst_hold");
      reset = 1'b0;
      start = 1;
      tick("post_start");
      start = 0;
      tick("post_adv");
      chk("post_adv.ifpc", if_pc, 64'd0);
      chk("post_adv.instr", {32'd0, if_instr}, 64'h9100_0421);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
